framebuffer_write_port: RTL and testbench

Receiving end of the pixel-write interface driven by our display generators (clear, fill, line and object renderers). Accepts one `(x, y, color)` write per clock when `writeEn` is high, range-checks it, converts it to a linear framebuffer address, and buffers it in a small FIFO. The FIFO drains to a single-port video memory that may stall, so generators can stream at full rate without backpressure.

---
 rtl/framebuffer_write_port.sv | 165 ++++++++++++++++
 tb/tb_framebuffer_write_port.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_write_port.sv
// Pixel-write port: range-checks (x,y,color), linearises to y*WIDTH+x and buffers in a FIFO to video memory.
// Latency: two cycles from writeEn to mem_we (capture register, then FIFO push) when the FIFO is empty.
// Backpressure: none upstream; mem_ready stalls the FIFO head and overflow drops (counted when FB_DROP_COUNT_EN).

module fb_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] push_dat,
    output logic [DW-1:0] head_dat,
    output logic          empty,
    output logic          full
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [DW-1:0] store [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= push_dat;
    end

    assign head_dat = store[rd_ptr];
    assign empty    = (cnt == '0);
    assign full     = (cnt == FULL_CNT);
endmodule

module framebuffer_write_port #(
    parameter int COLOR_CHANNEL_DEPTH = 2,
    parameter int WIDTH               = 160,
    parameter int HEIGHT              = 120,
    parameter int FIFO_DEPTH          = 4
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [7:0]                       x,
    input  logic [6:0]                       y,
    input  logic [3*COLOR_CHANNEL_DEPTH-1:0] color,
    input  logic                             writeEn,
    output logic [14:0]                      mem_addr,
    output logic [3*COLOR_CHANNEL_DEPTH-1:0] mem_data,
    output logic                             mem_we,
    input  logic                             mem_ready,
    output logic                             busy,
    output logic                             frame_done,
    output logic [15:0]                      drop_count
);
    localparam int CW = 3*COLOR_CHANNEL_DEPTH;

    typedef struct packed {
        logic          last;
        logic [14:0]   addr;
        logic [CW-1:0] color;
    } fb_entry_t;

    logic      in_range;
    logic      cap_last;
    logic [14:0] cap_base;
    fb_entry_t cap_ent;
    logic      s1_vld;
    fb_entry_t s1_ent;
    fb_entry_t head_ent;
    logic      fifo_empty;
    logic      fifo_full;
    logic      push;
    logic      pop;

    assign in_range = (32'(x) < 32'(WIDTH)) && (32'(y) < 32'(HEIGHT));
    assign cap_last = (32'(x) == 32'(WIDTH-1)) && (32'(y) == 32'(HEIGHT-1));

    generate
        if (WIDTH == 160) begin : g_mul160
            assign cap_base = ({8'b0, y} << 7) + ({8'b0, y} << 5);
        end else begin : g_mul
            assign cap_base = {8'b0, y} * 15'(WIDTH);
        end
    endgenerate

    assign cap_ent = '{last: cap_last, addr: cap_base + {7'b0, x}, color: color};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_vld <= 1'b0;
            s1_ent <= '0;
        end else begin
            s1_vld <= writeEn && in_range;
            s1_ent <= cap_ent;
        end
    end

    // A full FIFO still accepts the push when the head drains in the same cycle.
    assign pop  = mem_we && mem_ready;
    assign push = s1_vld && (!fifo_full || pop);

    fb_fifo #(
        .DW    ($bits(fb_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (push),
        .pop      (pop),
        .push_dat (s1_ent),
        .head_dat (head_ent),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // Head is masked while empty so the memory bus idles at zero.
    assign mem_we   = !fifo_empty;
    assign mem_addr = mem_we ? head_ent.addr  : '0;
    assign mem_data = mem_we ? head_ent.color : '0;
    assign busy     = s1_vld || !fifo_empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) frame_done <= 1'b0;
        else         frame_done <= pop && head_ent.last;
    end

`ifdef FB_DROP_COUNT_EN
    logic        s1_oor;
    logic        drop;
    logic [15:0] drop_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) s1_oor <= 1'b0;
        else         s1_oor <= writeEn && !in_range;
    end

    assign drop = s1_oor || (s1_vld && !push);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                             drop_q <= '0;
        else if (drop && (drop_q != 16'hFFFF))   drop_q <= drop_q + 16'd1;
    end

    assign drop_count = drop_q;
`else
    assign drop_count = 16'd0;
`endif
endmodule

// File: tb/tb_framebuffer_write_port.sv
// Directed and random stimulus for framebuffer_write_port, checked every cycle against a queue-based model.
module tb_framebuffer_write_port;
    localparam int W = 160;
    localparam int H = 120;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  x = '0;
    logic [6:0]  y = '0;
    logic [5:0]  color = '0;
    logic        writeEn = 1'b0;
    logic        mem_ready = 1'b0;
    logic [14:0] mem_addr;
    logic [5:0]  mem_data;
    logic        mem_we;
    logic        busy;
    logic        frame_done;
    logic [15:0] drop_count;

    framebuffer_write_port #(
        .COLOR_CHANNEL_DEPTH (2),
        .WIDTH               (W),
        .HEIGHT              (H),
        .FIFO_DEPTH          (D)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .x          (x),
        .y          (y),
        .color      (color),
        .writeEn    (writeEn),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int color;
        bit last;
    } ent_t;

    ent_t mq[$];
    ent_t p_ent;
    bit   p_vld;
    bit   p_oor;
    bit   m_fd;
    int   m_drop;

    int vectors = 0;
    int miscompares = 0;
    int popq[$];
    int fd_cnt;
    int step_no = 0;
    int last_pop_step;
    int fd_step;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_drop();
`ifdef FB_DROP_COUNT_EN
        return m_drop;
`else
        return 0;
`endif
    endfunction

    // One clock edge of the reference behaviour, using the inputs present before the edge.
    task automatic model_edge(input bit we, input int xi, input int yi, input int ci, input bit rdy);
        bit pop;
        bit full;
        pop  = (mq.size() > 0) && rdy;
        full = (mq.size() == D);
        m_fd = 1'b0;
        if (pop) begin
            m_fd = mq[0].last;
            void'(mq.pop_front());
        end
        if (p_vld) begin
            if (!full || pop) mq.push_back(p_ent);
            else              m_drop++;
        end
        if (p_oor) m_drop++;
        if (m_drop > 65535) m_drop = 65535;
        p_vld = we && (xi < W) && (yi < H);
        p_oor = we && !((xi < W) && (yi < H));
        p_ent.addr  = yi*W + xi;
        p_ent.color = ci;
        p_ent.last  = (xi == W-1) && (yi == H-1);
    endtask

    task automatic check_outputs();
        chk("mem_we", mem_we, mq.size() != 0);
        chk("mem_addr", mem_addr, (mq.size() != 0) ? mq[0].addr : 0);
        chk("mem_data", mem_data, (mq.size() != 0) ? mq[0].color : 0);
        chk("busy", busy, p_vld || (mq.size() != 0));
        chk("frame_done", frame_done, m_fd);
        chk("drop_count", drop_count, exp_drop());
    endtask

    task automatic step(input bit we, input int xi, input int yi, input int ci, input bit rdy);
        writeEn   = we;
        x         = 8'(xi);
        y         = 7'(yi);
        color     = 6'(ci);
        mem_ready = rdy;
        if (mem_we && rdy) begin
            popq.push_back(int'(mem_addr));
            last_pop_step = step_no + 1;
        end
        @(posedge clk);
        step_no++;
        model_edge(we, xi, yi, ci, rdy);
        #1;
        check_outputs();
        if (frame_done) begin
            fd_cnt++;
            fd_step = step_no;
        end
    endtask

    task automatic do_reset();
        resetn  = 1'b0;
        writeEn = 1'b0;
        #1;
        chk("rst_mem_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        mq.delete();
        p_vld  = 1'b0;
        p_oor  = 1'b0;
        m_fd   = 1'b0;
        m_drop = 0;
        popq.delete();
        fd_cnt = 0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        do_reset();

        // Full-screen raster at full rate.
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                step(1, xx, yy, 6'b010111, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        chk("fs_writes", popq.size(), W*H);
        begin
            int bad = 0;
            for (int i = 0; i < popq.size(); i++) if (popq[i] != i) bad++;
            chk("fs_order", bad, 0);
        end
        chk("fs_fd_count", fd_cnt, 1);
        chk("fs_fd_timing", fd_step, last_pop_step);
        chk("fs_drop", drop_count, 0);

        // Out-of-range writes never reach memory.
        do_reset();
        step(1, 160, 0, 1, 1);
        step(1, 0, 120, 2, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        chk("oor_writes", popq.size(), 0);
`ifdef FB_DROP_COUNT_EN
        chk("oor_drop", drop_count, 2);
`else
        chk("oor_drop", drop_count, 0);
`endif

        // Stall with six writes: four buffered, two dropped.
        do_reset();
        for (int i = 0; i < 6; i++) step(1, i, 0, i + 8, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        chk("stall_addr", mem_addr, 0);
`ifdef FB_DROP_COUNT_EN
        chk("stall_drop", drop_count, 2);
`endif
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
        chk("stall_npop", popq.size(), 4);
        for (int i = 0; i < 4; i++) chk("stall_pop_addr", (i < popq.size()) ? popq[i] : -1, i);
        chk("stall_busy", busy, 0);

        // Pop frees a slot for a push in the same full cycle.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, i, 0, 3, 0);
        step(1, 10, 0, 4, 0);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
        chk("pp_drop", drop_count, 0);
        chk("pp_npop", popq.size(), 5);
        chk("pp_last_addr", (popq.size() == 5) ? popq[4] : -1, 10);

        // Reset while three entries are buffered.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, i, 1, 5, 0);
        step(0, 0, 0, 0, 0);
        chk("mid_buffered", mem_we, 1);
        do_reset();
        step(1, 7, 3, 9, 1);
        chk("lat_we_n1", mem_we, 0);
        step(0, 0, 0, 0, 1);
        chk("lat_we_n2", mem_we, 1);
        chk("lat_addr", mem_addr, 3*W + 7);

        // Random traffic including out-of-range coordinates and stalls.
        do_reset();
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 170), $urandom_range(0, 127),
                 $urandom_range(0, 63), $urandom_range(0, 2) != 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
        chk("rand_idle", busy, 0);

`ifdef FB_DROP_COUNT_EN
        do_reset();
        for (int i = 0; i < 65540; i++) step(1, 200, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("sat_drop", drop_count, 16'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
